// File: rtl/fpu_dp_seq_multiplier.sv
// Iterative binary64 multiplier: one shift-add step per clock over the 53-bit significands,
// round-to-nearest-even, flush-to-zero for subnormal inputs and underflowing results.
module fpu_dp_seq_multiplier #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned MANT  = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             invalid
);

  localparam int unsigned FRAC_W = MANT - 1;
  localparam int unsigned EXP_W  = WIDTH - MANT;
  localparam int unsigned PROD_W = 2 * MANT;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned XW     = 13;

  localparam logic [EXP_W-1:0]    EXP_MAX = '1;
  localparam logic [WIDTH-1:0]    QNAN    = {1'b0, EXP_MAX, 1'b1, (FRAC_W-1)'(0)};
  localparam logic signed [XW-1:0] BIAS    = 13'sd1023;
  localparam logic signed [XW-1:0] EXP_OVF = 13'sd2047;
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(MANT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic                    sign_q;
  logic signed [XW-1:0]    exp_q;
  logic [PROD_W-1:0]       mcand_q;
  logic [PROD_W-1:0]       acc_q;
  logic [MANT-1:0]         mplier_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAC_W-1:0]       frac_q;
  logic                    guard_q;
  logic                    sticky_q;

  assign in_ready = (state == S_IDLE);

  // Operand classification (subnormals count as zero)
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [FRAC_W-1:0]    a_frac, b_frac;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                 sign_c;
  logic signed [XW-1:0] exp_sum_c;

  always_comb begin
    a_exp     = a_q[WIDTH-2 -: EXP_W];
    b_exp     = b_q[WIDTH-2 -: EXP_W];
    a_frac    = a_q[FRAC_W-1:0];
    b_frac    = b_q[FRAC_W-1:0];
    a_zero    = (a_exp == '0);
    b_zero    = (b_exp == '0);
    a_inf     = (a_exp == EXP_MAX) && (a_frac == '0);
    b_inf     = (b_exp == EXP_MAX) && (b_frac == '0);
    a_nan     = (a_exp == EXP_MAX) && (a_frac != '0);
    b_nan     = (b_exp == EXP_MAX) && (b_frac != '0);
    sign_c    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    exp_sum_c = $signed(XW'(a_exp)) + $signed(XW'(b_exp)) - BIAS;
  end

  // Normalisation of the raw product, value in [1,4) with the point at bit PROD_W-2
  logic                 prod_hi;
  logic [FRAC_W-1:0]    norm_frac_c;
  logic                 norm_guard_c;
  logic                 norm_sticky_c;
  logic signed [XW-1:0] norm_exp_c;

  always_comb begin
    prod_hi       = acc_q[PROD_W-1];
    norm_frac_c   = acc_q[PROD_W-3 -: FRAC_W];
    norm_guard_c  = acc_q[PROD_W-3-FRAC_W];
    norm_sticky_c = |acc_q[PROD_W-4-FRAC_W:0];
    norm_exp_c    = exp_q;
    if (prod_hi) begin
      norm_frac_c   = acc_q[PROD_W-2 -: FRAC_W];
      norm_guard_c  = acc_q[PROD_W-2-FRAC_W];
      norm_sticky_c = |acc_q[PROD_W-3-FRAC_W:0];
      norm_exp_c    = exp_q + 13'sd1;
    end
  end

  // Round to nearest even; a carry out of the significand bumps the exponent
  logic                 round_up_c;
  logic [MANT:0]        mant_rnd_c;
  logic [FRAC_W-1:0]    rnd_frac_c;
  logic signed [XW-1:0] rnd_exp_c;

  always_comb begin
    round_up_c = guard_q & (sticky_q | frac_q[0]);
    mant_rnd_c = {2'b01, frac_q} + (MANT+1)'(round_up_c);
    rnd_frac_c = mant_rnd_c[FRAC_W-1:0];
    rnd_exp_c  = exp_q;
    if (mant_rnd_c[MANT]) begin
      rnd_exp_c = exp_q + 13'sd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q       <= A;
            b_q       <= B;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            state     <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          sign_q <= sign_c;
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result    <= QNAN;
            invalid   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (a_inf || b_inf) begin
            result    <= {sign_c, EXP_MAX, FRAC_W'(0)};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (a_zero || b_zero) begin
            result    <= {sign_c, (WIDTH-1)'(0)};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            mcand_q  <= PROD_W'({1'b1, a_frac});
            mplier_q <= {1'b1, b_frac};
            exp_q    <= exp_sum_c;
            acc_q    <= '0;
            cnt_q    <= '0;
            state    <= S_MULT;
          end
        end

        // One multiplier bit per clock, LSB first
        S_MULT: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state <= S_NORM;
          end
        end

        S_NORM: begin
          frac_q   <= norm_frac_c;
          guard_q  <= norm_guard_c;
          sticky_q <= norm_sticky_c;
          exp_q    <= norm_exp_c;
          state    <= S_ROUND;
        end

        S_ROUND: begin
          if (rnd_exp_c >= EXP_OVF) begin
            result   <= {sign_q, EXP_MAX, FRAC_W'(0)};
            overflow <= 1'b1;
          end else if (rnd_exp_c <= 13'sd0) begin
            result    <= {sign_q, (WIDTH-1)'(0)};
            underflow <= 1'b1;
          end else begin
            result <= {sign_q, rnd_exp_c[EXP_W-1:0], rnd_frac_c};
          end
          state <= S_DONE;
        end

        // Normal results present one clock after entering; specials arrive already valid
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dp_seq_multiplier.sv
// Directed bench for fpu_dp_seq_multiplier: expectations queued at issue, checked on completion.
module tb_fpu_dp_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  fpu_dp_seq_multiplier #(.WIDTH(64), .MANT(53)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic        ov;
    logic        un;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Issue one operation, wait for it, check latency/result/flags, then complete the handshake
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input exp_t e, input int lat_exp, input bit hold);
    int   lat;
    bit   rdy_seen;
    exp_t want;
    wait_ready(tag);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = !hold;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready === 1'b1) rdy_seen = 1'b1;
      step();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, " in_ready low while busy"}, 64'(rdy_seen), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 64'd0, 64'd1);
      return;
    end
    want = sb.pop_front();
    chk({tag, " result"}, result, want.res);
    chk({tag, " flags ov/un/inv"}, 64'({overflow, underflow, invalid}),
        64'({want.ov, want.un, want.inv}));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        if (i == 0) begin
          A        = 64'h4000000000000000;
          B        = 64'h4000000000000000;
          in_valid = 1'b1;
        end
        step();
        chk({tag, " held result"}, result, want.res);
        chk({tag, " held ov/un/inv/in_ready/out_valid"},
            64'({overflow, underflow, invalid, in_ready, out_valid}),
            64'({want.ov, want.un, want.inv, 1'b0, 1'b1}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk({tag, " post-handshake in_ready/out_valid"}, 64'({in_ready, out_valid}), 64'b10);
    if (hold) begin
      step();
      chk({tag, " ignored operands"}, 64'({in_ready, out_valid}), 64'b10);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic ov, input logic un, input logic inv);
    mk = '{res: r, ov: ov, un: un, inv: inv};
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    step();
    step();
    chk("reset result", result, 64'd0);
    chk("reset out_valid/ov/un/inv", 64'({out_valid, overflow, underflow, invalid}), 64'd0);
    rst = 1'b0;
    step();
    chk("reset in_ready", 64'(in_ready), 64'd1);

    run_op("basic 1.5*2", 64'h3FF8000000000000, 64'h4000000000000000,
           mk(64'h4008000000000000, 0, 0, 0), 57, 0);
    run_op("round sticky", 64'h3FF0000000000001, 64'h3FF0000000000001,
           mk(64'h3FF0000000000002, 0, 0, 0), 57, 0);
    run_op("round tie-even", 64'h3FF0000000000001, 64'h3FF8000000000000,
           mk(64'h3FF8000000000002, 0, 0, 0), 57, 0);
    run_op("overflow pos", 64'h7FE0000000000000, 64'h4000000000000000,
           mk(64'h7FF0000000000000, 1, 0, 0), 57, 0);
    run_op("overflow neg", 64'hFFE0000000000000, 64'h4000000000000000,
           mk(64'hFFF0000000000000, 1, 0, 0), 57, 0);
    run_op("underflow", 64'h0010000000000000, 64'h3FE0000000000000,
           mk(64'h0000000000000000, 0, 1, 0), 57, 0);
    run_op("subnormal ftz", 64'h0000000000000001, 64'h4000000000000000,
           mk(64'h0000000000000000, 0, 0, 0), 1, 0);
    run_op("inf*zero", 64'h7FF0000000000000, 64'h0000000000000000,
           mk(64'h7FF8000000000000, 0, 0, 1), 1, 0);
    run_op("nan operand", 64'hC000000000000000, 64'h7FF0000000000001,
           mk(64'h7FF8000000000000, 0, 0, 1), 1, 0);
    run_op("neg*inf", 64'hC000000000000000, 64'h7FF0000000000000,
           mk(64'hFFF0000000000000, 0, 0, 0), 1, 0);
    run_op("backpressure 3*-1.5", 64'h4008000000000000, 64'hBFF8000000000000,
           mk(64'hC012000000000000, 0, 0, 0), 57, 1);

    // Abort an operation mid-multiply with reset
    wait_ready("abort");
    A        = 64'h3FF8000000000000;
    B        = 64'h4000000000000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (21) step();
    chk("abort busy before reset", 64'({in_ready, out_valid}), 64'b00);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", result, 64'd0);
    step();
    rst = 1'b0;
    run_op("after abort", 64'h3FF8000000000000, 64'h4000000000000000,
           mk(64'h4008000000000000, 0, 0, 0), 57, 0);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_dp_seq_multiplier.md
Name: fpu_dp_seq_multiplier

Overview:
Iterative IEEE-754 double-precision multiplier with valid/ready handshakes on input and output. It is the multiply-direction companion to the reciprocal-based divider. The FPU uses it where area matters more than latency: one 53x53 mantissa product is built with one shift-add step per clock. Outputs are a registered 64-bit result plus overflow, underflow and invalid flags.

Parameters:
WIDTH, 64, operand/result width; only 64 (binary64: 1 sign, 11 exponent, 52 fraction) is supported.
MANT, 53, significand width including the hidden bit; it sets the MULT iteration count.

Ports:
clk  input  1  clock, all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands A/B valid
in_ready  output  1  block can accept operands
A  input  WIDTH  multiplicand, binary64
B  input  WIDTH  multiplier, binary64
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  A*B, binary64
overflow  output  1  result overflowed to signed infinity
underflow  output  1  result flushed to signed zero
invalid  output  1  NaN operand or Inf*0

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0, overflow=0, underflow=0, invalid=0, out_valid=0; in_ready=1 after release. Reset mid-operation abandons the operation with no output.
- in_ready = (state==IDLE), driven combinationally from state. Accept on an edge where in_valid&&in_ready (edge N): register A and B; state->UNPACK.
- States:
  - IDLE: wait for accept.
  - UNPACK: classify operands; subnormal inputs are treated as zero (flush-to-zero). Special case -> DONE at N+1. Otherwise load significands {1,frac} and exp_sum = ea+eb-1023 (13-bit signed); clear the 106-bit accumulator; state->MULT.
  - MULT: 53 cycles (N+2..N+54). Each cycle add the shifted multiplicand if the current multiplier bit is 1; step counter 0..52. At count 52 -> NORM.
  - NORM (N+55): if product bit 105=1, shift right 1 and exp_sum+1. Take 52 fraction bits, guard bit, and sticky = OR of the remaining bits.
  - ROUND (N+56): round-to-nearest-even. A mantissa carry-out renormalizes and adds 1 to the exponent. Then:
    - exp>=2047: result {s,0x7FF,0}, overflow=1.
    - exp<=0: result {s,63'b0}, underflow=1.
    - otherwise: pack the normal result.
    Then state->DONE.
  - DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready, then state->IDLE. in_ready rises the following cycle; the same edge never accepts new operands.
- Latency from accept edge N to out_valid high: 57 clocks for normal operands, 1 clock for special cases. Flags are registered with result and cleared on each accept.
- Special cases (sign s = sA^sB in every case):
  - Either operand NaN, or Inf*0: result 0x7FF8000000000000, invalid=1.
  - Inf*nonzero: result signed Inf, no flags.
  - Zero (or flushed subnormal) * finite: result signed zero, no flags.
- Sign is always sA^sB, except canonical NaN, whose sign is 0.
- Exponent arithmetic uses 13-bit signed values; no wrap is permitted.

Test Plan:
- A=0x3FF8000000000000 (1.5), B=0x4000000000000000 (2.0), out_ready=1 -> result 0x4008000000000000, all flags 0; out_valid exactly 57 clocks after accept; in_ready low throughout.
- Rounding, 0x3FF0000000000001 * 0x3FF0000000000001 -> 0x3FF0000000000002. Tie-to-even, 0x3FF0000000000001 * 0x3FF8000000000000 -> 0x3FF8000000000002.
- Overflow, 0x7FE0000000000000 * 0x4000000000000000 -> 0x7FF0000000000000 with overflow=1. Also 0xFFE0000000000000 * 0x4000000000000000 -> 0xFFF0000000000000 with overflow=1.
- Underflow, 0x0010000000000000 * 0x3FE0000000000000 -> 0x0000000000000000 with underflow=1. Subnormal input, 0x0000000000000001 * 0x4000000000000000 -> 0x0000000000000000, no flags.
- Specials:
  - 0x7FF0000000000000 * 0x0000000000000000 -> 0x7FF8000000000000, invalid=1, out_valid 1 clock after accept.
  - 0xC000000000000000 * 0x7FF0000000000001 -> 0x7FF8000000000000, invalid=1.
  - 0xC000000000000000 * 0x7FF0000000000000 -> 0xFFF0000000000000.
- Handshake/reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0; a new in_valid is ignored.
  - Release out_ready -> IDLE, in_ready=1 next cycle.
  - Assert rst at MULT step 20 -> out_valid=0, result=0 immediately; the next operation completes correctly.
